// File: rtl/reg_file_pkg.sv
// Shared constants and types for the reg_file_sb register file and its scoreboard.
package reg_file_pkg;

  localparam int unsigned SIZE_DEF   = 8;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned ZERO_ADDR  = 0;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } rd_port_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: reservation sets, write-back clears, reservation wins on collision.
// With REG_FILE_SB_BYPASS_EN defined, a same-cycle write-back masks the per-port busy lookup.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int unsigned ADDR_W   = ADDR_W_DEF,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                rsv_en_i,
  input  logic [ADDR_W-1:0]   rsv_addr_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [ADDR_W-1:0]   addr_a_i,
  input  logic [ADDR_W-1:0]   addr_b_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                busy_a_c,
  output logic                busy_b_c
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clear first so a same-edge reservation overrides the write-back.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (rsv_en_i) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef REG_FILE_SB_BYPASS_EN
  logic wr_hit_a, wr_hit_b;

  always_comb begin
    wr_hit_a = wr_en_i && (wr_addr_i == addr_a_i);
    wr_hit_b = wr_en_i && (wr_addr_i == addr_b_i);
    busy_a_c = busy_q[addr_a_i] & ~wr_hit_a;
    busy_b_c = busy_q[addr_b_i] & ~wr_hit_b;
  end
`else
  always_comb begin
    busy_a_c = busy_q[addr_a_i];
    busy_b_c = busy_q[addr_b_i];
  end
`endif

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with busy scoreboard; entry 0 reads as zero.
// Optional REG_FILE_SB_BYPASS_EN forwards a same-cycle write-back to the read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int unsigned SIZE     = SIZE_DEF,
  parameter  int unsigned ADDR_W   = ADDR_W_DEF,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_a_i,
  input  logic [ADDR_W-1:0]   rd_addr_b_i,
  output logic [SIZE-1:0]     dout_a_o,
  output logic [SIZE-1:0]     dout_b_o,
  output logic                rd_valid_o,
  output logic                stall_o,
  input  logic                rsv_en_i,
  input  logic [ADDR_W-1:0]   rsv_addr_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [SIZE-1:0]     din_i,
  output logic [NUM_REGS-1:0] busy_o
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_ADDR);

  logic [NUM_REGS-1:0][SIZE-1:0] mem_q, mem_d;
  logic [SIZE-1:0]               dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [SIZE-1:0]               rd_a_c, rd_b_c;
  logic                          busy_a_c, busy_b_c, accept_c;

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .addr_a_i   (rd_addr_a_i),
    .addr_b_i   (rd_addr_b_i),
    .busy_o     (busy_o),
    .busy_a_c   (busy_a_c),
    .busy_b_c   (busy_b_c)
  );

  // Read muxes see pre-write storage unless the write is forwarded.
  always_comb begin
    rd_a_c = (rd_addr_a_i == ZERO_IDX) ? '0 : mem_q[rd_addr_a_i];
    rd_b_c = (rd_addr_b_i == ZERO_IDX) ? '0 : mem_q[rd_addr_b_i];
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en_i && (wr_addr_i != ZERO_IDX) && (wr_addr_i == rd_addr_a_i)) begin
      rd_a_c = din_i;
    end
    if (wr_en_i && (wr_addr_i != ZERO_IDX) && (wr_addr_i == rd_addr_b_i)) begin
      rd_b_c = din_i;
    end
`endif
  end

  assign stall_o  = rd_en_i & (busy_a_c | busy_b_c);
  assign accept_c = rd_en_i & ~stall_o;

  always_comb begin
    mem_d      = mem_q;
    dout_a_d   = dout_a_q;
    dout_b_d   = dout_b_q;
    rd_valid_d = accept_c;
    if (wr_en_i && (wr_addr_i != ZERO_IDX)) begin
      mem_d[wr_addr_i] = din_i;
    end
    if (accept_c) begin
      dout_a_d = rd_a_c;
      dout_b_d = rd_b_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q      <= '0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      dout_a_q   <= dout_a_d;
      dout_b_q   <= dout_b_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign dout_a_o   = dout_a_q;
  assign dout_b_o   = dout_b_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 8-entry, 2-read/1-write register file with a per-register busy scoreboard; entry 0 is hardwired to zero.
- Sits directly upstream of the zero/data register stage.
- Issue logic reserves a destination, then reads operands. The read stalls while any source register is still pending write-back.
- Write-back clears the reservation.

Parameters:
- SIZE, 8, data width in bits.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W (derived localparam, not overridable).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- rd_en_i  input  1  operand read request.
- rd_addr_a_i  input  ADDR_W  source A index.
- rd_addr_b_i  input  ADDR_W  source B index.
- dout_a_o  output  SIZE  registered source A data.
- dout_b_o  output  SIZE  registered source B data.
- rd_valid_o  output  1  dout_a_o/dout_b_o updated this cycle.
- stall_o  output  1  read request blocked by scoreboard (combinational).
- rsv_en_i  input  1  reserve destination register.
- rsv_addr_i  input  ADDR_W  destination index to reserve.
- wr_en_i  input  1  write-back strobe.
- wr_addr_i  input  ADDR_W  write-back index.
- din_i  input  SIZE  write-back data.
- busy_o  output  NUM_REGS  scoreboard bit vector; bit 0 is always 0.

Behaviour:
- Reset (asynchronous, rst_n_i low): all storage, dout_a_o, dout_b_o, rd_valid_o and busy_o clear to 0. Reset mid-operation discards pending reservations and in-flight reads. First accepted read after reset sees all zeros.
- Index 0: reads always return 0. Writes and reservations to index 0 are ignored; busy[0] is never set.
- Write: on a clock edge with wr_en_i=1, mem[wr_addr_i] <= din_i and busy[wr_addr_i] clears. Writes are accepted whether or not the register is busy.
- Reserve: on a clock edge with rsv_en_i=1, busy[rsv_addr_i] is set.
- Reserve and write to the same index on the same edge: reservation wins; the data is written and busy stays 1.
- Stall: stall_o = rd_en_i & (busy[rd_addr_a_i] | busy[rd_addr_b_i]), evaluated on current busy state.
- Read accept: read accepted when rd_en_i=1 and stall_o=0. Latency is 1 cycle: next cycle dout_a_o/dout_b_o show the values and rd_valid_o=1 for exactly one cycle.
- No accept: dout_a_o/dout_b_o hold their previous values and rd_valid_o=0.
- Same-cycle write and read of the same index, without bypass: read-before-write. The old value is returned, and stall is computed from pre-write busy state.
- rd_addr_a_i == rd_addr_b_i is legal; both outputs carry the same value.
- Reserving an already busy register keeps it busy; no counting.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined: a same-cycle write forwards to the read.
  - Any read port whose address matches wr_addr_i (nonzero) with wr_en_i=1 takes din_i.
  - That source is treated as not busy for stall_o.
  - Stall becomes: busy & ~(wr_en_i & wr_addr_i==addr).
- Undefined: read-before-write as above; one extra stall cycle after write-back.

Decomposition:
- Shared package reg_file_pkg:
  - ZERO_ADDR = 0.
  - Default SIZE/ADDR_W constants.
  - A read-port enum (PORT_A, PORT_B) used for bench indexing.
- One natural sub-module, rf_scoreboard. It holds the busy vector, applies set/clear priority, and produces the per-port busy lookups used by the stall logic.
- Storage and read muxing stay in the top.

Test Plan:
- Reset and read:
  - Stimulus: reset, then rd_en_i=1, a=3, b=5.
  - Response: no stall; next cycle rd_valid_o=1, dout_a_o=0x00, dout_b_o=0x00.
- Write then read:
  - Stimulus: write 0xA5 to reg 2, then 0x3C to reg 7; next cycle read a=2, b=7.
  - Response: next cycle dout_a_o=0xA5, dout_b_o=0x3C.
- Index 0:
  - Stimulus: write 0xFF to reg 0 with rsv_en_i=1, rsv_addr_i=0; then read a=0.
  - Response: busy_o=0x00; dout_a_o=0x00.
- Scoreboard:
  - Stimulus: reserve reg 4; read a=4 next cycle.
  - Response: stall_o=1, rd_valid_o stays 0, outputs hold.
  - Stimulus: write 0x11 to reg 4.
  - Response (bypass off): stall clears the following cycle, dout_a_o=0x11. Response (bypass on): no stall in the write cycle, dout_a_o=0x11.
- Set/clear collision:
  - Stimulus: reserve and write reg 6 (0x77) on the same edge.
  - Response: busy_o[6]=1; after a later write with 0x88, a read returns 0x88.
- Mid-operation reset:
  - Stimulus: busy_o=0x1E with stored data present; pulse rst_n_i low between clock edges.
  - Response: busy_o=0x00, dout_a_o/dout_b_o=0 immediately; a read of reg 2 afterwards returns 0x00.
